// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, start-glitch rejection
// and framing-error detection with a single error pulse per held-low line.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e state_q, state_d;

    logic                 sync1_q;
    logic                 rx_s;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= UART_RX;
            rx_s    <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            shift_d[i] = rx_s;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        rx_data      = data_q;
        rx_valid     = valid_q;
        rx_frame_err = err_q;
        rx_busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written sequences for
// back-to-back frames, start glitches, held-low breaks and reset mid-frame.
module tb_uart_rx;

    localparam int Clks = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int fall_cyc = 0;
    int valid_cyc = -1;
    logic busy_at_valid = 1'b1;
    logic prev_pulse = 1'b0;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(
        .CLKS_PER_BIT(Clks),
        .DATA_BITS   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .UART_RX     (line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) begin
            check("pulse_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
        end
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
            if (valid_cyc < 0) begin
                valid_cyc = cyc;
                busy_at_valid = rx_busy;
            end
        end
        if (rx_frame_err) n_err++;
        prev_pulse = rx_valid | rx_frame_err;
    end

    task automatic clear_mon();
        n_valid = 0;
        n_err = 0;
        got_q.delete();
        valid_cyc = -1;
        busy_at_valid = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        line = 1'b0;
        fall_cyc = cyc;
        wait_cycles(Clks);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            wait_cycles(Clks);
        end
        line = stop;
        wait_cycles(Clks);
        line = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int k;
        int lat;
        logic [7:0] bits81;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h00};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};
        vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_data: 8'hFF};
        vecs[4] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h5A};
        vecs[5] = '{data: 8'h81, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h81};

        // Reset held with line idle
        @(negedge clk);
        reset = 1'b1;
        line = 1'b1;
        wait_cycles(10);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_err", 32'(rx_frame_err), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        wait_cycles(4);
        check("idle_busy", 32'(rx_busy), 32'd0);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_frame(vecs[i].data, vecs[i].stop);
            wait_cycles(24);
            check($sformatf("vec%0d_valid_count", i), 32'(n_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err_count", i), 32'(n_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'd0);
            if (i == 0) begin
                lat = valid_cyc - fall_cyc;
                check("latency_in_154_155", 32'(lat >= 154 && lat <= 155), 32'd1);
                check("busy_drops_with_valid", 32'(busy_at_valid), 32'd0);
            end
        end

        // Back-to-back frames, one stop bit, no idle gap
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(24);
        check("b2b_count", 32'(n_valid), 32'd2);
        check("b2b_first", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'h00);
        check("b2b_second", 32'(got_q.size() > 1 ? got_q[1] : 8'hXX), 32'hFF);

        // Start glitch: 5 cycles low
        clear_mon();
        line = 1'b0;
        wait_cycles(5);
        line = 1'b1;
        k = 0;
        while (rx_busy && k < 12) begin
            @(negedge clk);
            k++;
        end
        check("glitch_busy_low", 32'(rx_busy), 32'd0);
        wait_cycles(200);
        check("glitch_no_valid", 32'(n_valid), 32'd0);
        check("glitch_no_err", 32'(n_err), 32'd0);

        // Frame 0x3C with stop low, line held low 40 cycles
        clear_mon();
        line = 1'b0;
        wait_cycles(Clks);
        for (int i = 0; i < 8; i++) begin
            line = bit'((8'h3C >> i) & 8'h01);
            wait_cycles(Clks);
        end
        line = 1'b0;
        wait_cycles(30);
        check("break_busy", 32'(rx_busy), 32'd1);
        wait_cycles(10);
        line = 1'b1;
        wait_cycles(24);
        check("break_err_count", 32'(n_err), 32'd1);
        check("break_valid_count", 32'(n_valid), 32'd0);
        check("break_data_kept", 32'(rx_data), 32'hFF);
        check("break_busy_after", 32'(rx_busy), 32'd0);
        clear_mon();
        send_frame(8'h5A, 1'b1);
        wait_cycles(24);
        check("after_break_count", 32'(n_valid), 32'd1);
        check("after_break_data", 32'(rx_data), 32'h5A);

        // Reset pulsed during data bit 4 of 0x81
        clear_mon();
        bits81 = 8'h81;
        line = 1'b0;
        wait_cycles(Clks);
        for (int i = 0; i < 4; i++) begin
            line = bits81[i];
            wait_cycles(Clks);
        end
        line = bits81[4];
        wait_cycles(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        line = 1'b1;
        check("midreset_busy", 32'(rx_busy), 32'd0);
        check("midreset_data", 32'(rx_data), 32'h00);
        wait_cycles(200);
        check("midreset_no_valid", 32'(n_valid), 32'd0);
        check("midreset_no_err", 32'(n_err), 32'd0);
        clear_mon();
        send_frame(8'h7E, 1'b1);
        wait_cycles(24);
        check("after_reset_count", 32'(n_valid), 32'd1);
        check("after_reset_data", 32'(rx_data), 32'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
